// File: rtl/fp_addsub_param_if.sv
// Operand/result handshake bundle for fp_addsub_param.
// master = operand producer / result consumer, slave = the adder.
interface fp_addsub_param_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic [W-1:0] input_a;
  logic         input_a_stb;
  logic         input_a_ack;
  logic [W-1:0] input_b;
  logic         input_b_stb;
  logic         input_b_ack;
  logic         input_op;
  logic [W-1:0] output_z;
  logic         output_z_stb;
  logic         output_z_ack;
  logic [3:0]   output_flags;

  modport master (
    output input_a, input_a_stb, input_b, input_b_stb, input_op, output_z_ack,
    input  input_a_ack, input_b_ack, output_z, output_z_stb, output_flags
  );

  modport slave (
    input  input_a, input_a_stb, input_b, input_b_stb, input_op, output_z_ack,
    output input_a_ack, input_b_ack, output_z, output_z_stb, output_flags
  );
endinterface

// File: rtl/fp_addsub_param.sv
// Parametrised floating-point add/subtract, fixed-latency multi-cycle FSM,
// round-to-nearest-even, flags {invalid, overflow, underflow, inexact}.
// Optional feature macro: FP_ADDSUB_SUBNORM_EN (gradual underflow). When it is
// undefined, subnormal inputs read as signed zero and subnormal results flush.
module fp_addsub_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic           clk,
  input logic           rstnn,
  fp_addsub_param_if.slave bus
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int SW  = MAN_W + 4;               // hidden, fraction, G, R, S
  localparam int EW  = EXP_W + 1;               // one spare bit to catch overflow
  localparam int LZW = $clog2(SW + 1);
  localparam int CW  = (LZW > EW) ? LZW : EW;   // width for shift-amount math
`ifdef FP_ADDSUB_SUBNORM_EN
  localparam bit SUBNORM = 1'b1;
`else
  localparam bit SUBNORM = 1'b0;
`endif
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [EW-1:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  typedef enum logic [3:0] {
    IDLE, UNPACK, SPECIAL, ALIGN, ADD, NORM, ROUND, PACK, OUT
  } state_t;

  state_t             state;
  logic               ack, z_stb;
  logic [W-1:0]       z_out;
  logic [3:0]         f_out;
  logic [W-1:0]       a_raw, b_raw;
  logic               op_r;
  logic               a_s, b_s;
  logic [EXP_W-1:0]   a_e, b_e;
  logic [MAN_W:0]     a_m, b_m;
  logic               l_s, eff_sub;
  logic [EXP_W-1:0]   l_e;
  logic [SW-1:0]      l_m, s_al;
  logic [SW:0]        sum;
  logic               ad_s;
  logic               n_s;
  logic [EW-1:0]      n_e;
  logic [SW-1:0]      n_m;
  logic               r_s, r_inx, r_tiny;
  logic [EW-1:0]      r_e;
  logic [MAN_W:0]     r_m;
  logic [W-1:0]       z_r;
  logic [3:0]         f_r;

  assign bus.input_a_ack  = ack;
  assign bus.input_b_ack  = ack;
  assign bus.output_z     = z_out;
  assign bus.output_z_stb = z_stb;
  assign bus.output_flags = f_out;

  logic [EXP_W-1:0] a_ef, b_ef;
  logic [MAN_W-1:0] a_fr, b_fr;
  assign a_ef = a_raw[W-2:MAN_W];
  assign b_ef = b_raw[W-2:MAN_W];
  assign a_fr = a_raw[MAN_W-1:0];
  assign b_fr = b_raw[MAN_W-1:0];

  function automatic logic [CW-1:0] lzc(input logic [SW-1:0] v);
    lzc = CW'(SW);
    for (int i = 0; i < SW; i++)
      if (v[i]) lzc = CW'(SW - 1 - i);
  endfunction

  // NaN / infinity resolution from the raw fields
  logic a_nan, b_nan, a_inf, b_inf, inf_clash, spc_hit;
  logic [W-1:0] spc_z;
  logic [3:0]   spc_f;
  always_comb begin
    a_nan     = (&a_ef) && (|a_fr);
    b_nan     = (&b_ef) && (|b_fr);
    a_inf     = (&a_ef) && !(|a_fr);
    b_inf     = (&b_ef) && !(|b_fr);
    inf_clash = a_inf && b_inf && (a_s != b_s);
    spc_hit   = a_nan || b_nan || a_inf || b_inf;
    spc_z     = QNAN;
    spc_f     = 4'b0000;
    if (a_nan || b_nan || inf_clash) begin
      spc_f[3] = inf_clash || (a_nan && !a_fr[MAN_W-1]) || (b_nan && !b_fr[MAN_W-1]);
    end else if (a_inf) begin
      spc_z = {a_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      spc_z = {b_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  // swap to |large| >= |small| and barrel-shift the small significand with sticky
  logic             a_ge;
  logic [EXP_W-1:0] al_d, s_e_c;
  logic [MAN_W:0]   s_m_c;
  logic [SW-1:0]    sm, sh, al_s;
  always_comb begin
    a_ge  = {a_e, a_m} >= {b_e, b_m};
    s_e_c = a_ge ? b_e : a_e;
    s_m_c = a_ge ? b_m : a_m;
    al_d  = (a_ge ? a_e : b_e) - s_e_c;
    sm    = {s_m_c, 3'b000};
    sh    = sm >> al_d;
    al_s  = {sh[SW-1:1], sh[0] | (|(sm & ~({SW{1'b1}} << al_d)))};
  end

  // magnitude add or subtract, carry bit on top
  logic [SW:0] add_sum;
  always_comb begin
    add_sum = eff_sub ? ({1'b0, l_m} - {1'b0, s_al}) : ({1'b0, l_m} + {1'b0, s_al});
  end

  // normalise: carry -> shift right keeping sticky, else left by clamped lz count
  logic [CW-1:0] nz_lz, nz_lim, nz_sh;
  logic [SW-1:0] nm_c;
  logic [EW-1:0] ne_c;
  always_comb begin
    nz_lz  = '0;
    nz_lim = '0;
    nz_sh  = '0;
    nm_c   = sum[SW-1:0];
    ne_c   = EW'(l_e);
    if (sum[SW]) begin
      nm_c = {sum[SW:2], sum[1] | sum[0]};
      ne_c = EW'(l_e) + EW'(1);
    end else begin
      nz_lz  = lzc(sum[SW-1:0]);
      nz_lim = CW'(l_e) - CW'(1);
      nz_sh  = (nz_lz < nz_lim) ? nz_lz : nz_lim;
      nm_c   = sum[SW-1:0] << nz_sh;
      ne_c   = EW'(CW'(l_e) - nz_sh);
    end
  end

  // round-to-nearest-even increment on G/R/S
  logic           rnd_up;
  logic [MAN_W+1:0] rnd_m;
  always_comb begin
    rnd_up = n_m[2] && (n_m[1] || n_m[0] || n_m[3]);
    rnd_m  = {1'b0, n_m[SW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
  end

  // final encoding: overflow to inf, optional flush, subnormal field = 0
  logic [W-1:0] pk_z;
  logic [3:0]   pk_f;
  always_comb begin
    pk_z = {r_s, (r_m[MAN_W] ? r_e[EXP_W-1:0] : {EXP_W{1'b0}}), r_m[MAN_W-1:0]};
    pk_f = {2'b00, r_tiny && r_inx, r_inx};
    if (r_e >= EXP_MAX) begin
      pk_z = {r_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      pk_f = 4'b0101;
    end else if (!SUBNORM && !r_m[MAN_W] && (|r_m)) begin
      pk_z = {r_s, {(W-1){1'b0}}};
      pk_f = 4'b0011;
    end
  end

  // control FSM and all datapath stage registers
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state <= IDLE;
      ack <= 1'b0; z_stb <= 1'b0; z_out <= '0; f_out <= '0;
      a_raw <= '0; b_raw <= '0; op_r <= 1'b0;
      a_s <= 1'b0; b_s <= 1'b0; a_e <= '0; b_e <= '0; a_m <= '0; b_m <= '0;
      l_s <= 1'b0; eff_sub <= 1'b0; l_e <= '0; l_m <= '0; s_al <= '0;
      sum <= '0; ad_s <= 1'b0;
      n_s <= 1'b0; n_e <= '0; n_m <= '0;
      r_s <= 1'b0; r_inx <= 1'b0; r_tiny <= 1'b0; r_e <= '0; r_m <= '0;
      z_r <= '0; f_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!ack) begin
            ack <= 1'b1;
          end else if (bus.input_a_stb && bus.input_b_stb) begin
            a_raw <= bus.input_a;
            b_raw <= bus.input_b;
            op_r  <= bus.input_op;
            ack   <= 1'b0;
            state <= UNPACK;
          end
        end
        UNPACK: begin
          a_s <= a_raw[W-1];
          b_s <= b_raw[W-1] ^ op_r;
          if (a_ef == '0) begin
            a_e <= EXP_W'(1);
            a_m <= SUBNORM ? {1'b0, a_fr} : '0;
          end else begin
            a_e <= a_ef;
            a_m <= {1'b1, a_fr};
          end
          if (b_ef == '0) begin
            b_e <= EXP_W'(1);
            b_m <= SUBNORM ? {1'b0, b_fr} : '0;
          end else begin
            b_e <= b_ef;
            b_m <= {1'b1, b_fr};
          end
          state <= SPECIAL;
        end
        SPECIAL: begin
          if (spc_hit) begin
            z_r   <= spc_z;
            f_r   <= spc_f;
            state <= OUT;
          end else begin
            state <= ALIGN;
          end
        end
        ALIGN: begin
          l_s     <= a_ge ? a_s : b_s;
          l_e     <= a_ge ? a_e : b_e;
          l_m     <= {(a_ge ? a_m : b_m), 3'b000};
          s_al    <= al_s;
          eff_sub <= a_s ^ b_s;
          state   <= ADD;
        end
        ADD: begin
          sum   <= add_sum;
          // exact zero is +0 unless both operands were zeros of sign 1
          ad_s  <= (add_sum == '0) ? (l_s && !eff_sub) : l_s;
          state <= NORM;
        end
        NORM: begin
          n_s   <= ad_s;
          n_m   <= nm_c;
          n_e   <= ne_c;
          state <= ROUND;
        end
        ROUND: begin
          r_s    <= n_s;
          r_inx  <= |n_m[2:0];
          r_tiny <= !n_m[SW-1];
          if (rnd_m[MAN_W+1]) begin
            r_m <= rnd_m[MAN_W+1:1];
            r_e <= n_e + EW'(1);
          end else begin
            r_m <= rnd_m[MAN_W:0];
            r_e <= n_e;
          end
          state <= PACK;
        end
        PACK: begin
          z_r   <= pk_z;
          f_r   <= pk_f;
          state <= OUT;
        end
        OUT: begin
          if (!z_stb) begin
            z_stb <= 1'b1;
            z_out <= z_r;
            f_out <= f_r;
          end else if (bus.output_z_ack) begin
            z_stb <= 1'b0;
            ack   <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_addsub_param.sv
// Directed bench for fp_addsub_param: fp32 and fp16 instances, vector table
// plus hand sequences for back-pressure, single strobe and mid-flight reset.
module tb_fp_addsub_param;
  logic clk = 1'b0;
  logic rstnn = 1'b0;
  always #5 clk = ~clk;

  fp_addsub_param_if #(.EXP_W(8), .MAN_W(23)) i32 ();
  fp_addsub_param_if #(.EXP_W(5), .MAN_W(10)) i16 ();

  fp_addsub_param #(.EXP_W(8), .MAN_W(23)) u32 (.clk(clk), .rstnn(rstnn), .bus(i32.slave));
  fp_addsub_param #(.EXP_W(5), .MAN_W(10)) u16 (.clk(clk), .rstnn(rstnn), .bus(i16.slave));

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          h;     // 1 = fp16 instance
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] z;
    logic [3:0]  f;
    int          lat;
  } vec_t;

  localparam int NV = 18;
  vec_t vt [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_op(input bit h, input logic [31:0] a, input logic [31:0] b,
                        input logic op, output logic [31:0] z, output logic [3:0] f,
                        output int lat);
    int n = 0;
    while (!(h ? i16.input_a_ack : i32.input_a_ack) && n < 30) begin
      @(posedge clk); #1; n++;
    end
    @(negedge clk);
    if (h) begin
      i16.input_a = a[15:0]; i16.input_b = b[15:0]; i16.input_op = op;
      i16.input_a_stb = 1'b1; i16.input_b_stb = 1'b1;
    end else begin
      i32.input_a = a; i32.input_b = b; i32.input_op = op;
      i32.input_a_stb = 1'b1; i32.input_b_stb = 1'b1;
    end
    @(posedge clk); #1;
    i16.input_a_stb = 1'b0; i16.input_b_stb = 1'b0;
    i32.input_a_stb = 1'b0; i32.input_b_stb = 1'b0;
    lat = 0;
    while (!(h ? i16.output_z_stb : i32.output_z_stb) && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    z = h ? {16'h0000, i16.output_z} : i32.output_z;
    f = h ? i16.output_flags : i32.output_flags;
  endtask

  initial begin
    logic [31:0] z;
    logic [3:0]  f;
    int lat;
    bit ok;

    vt[0]  = '{0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 8};
    vt[1]  = '{0, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, 8};
    vt[2]  = '{0, 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, 8};
    vt[3]  = '{0, 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000, 3};
    vt[4]  = '{0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, 8};
    vt[5]  = '{0, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 8};
`ifdef FP_ADDSUB_SUBNORM_EN
    vt[6]  = '{0, 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'b0000, 8};
    vt[7]  = '{0, 32'h00C00000, 32'h00800000, 1'b1, 32'h00400000, 4'b0000, 8};
    vt[8]  = '{0, 32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 4'b0000, 8};
`else
    vt[6]  = '{0, 32'h00000001, 32'h00000001, 1'b0, 32'h00000000, 4'b0000, 8};
    vt[7]  = '{0, 32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 4'b0011, 8};
    vt[8]  = '{0, 32'h00800000, 32'h00000001, 1'b1, 32'h00800000, 4'b0000, 8};
`endif
    vt[9]  = '{0, 32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000, 3};
    vt[10] = '{0, 32'h7F800001, 32'h00000000, 1'b0, 32'h7FC00000, 4'b1000, 3};
    vt[11] = '{0, 32'h7F800000, 32'hFF800000, 1'b1, 32'h7F800000, 4'b0000, 3};
    vt[12] = '{0, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000, 8};
    vt[13] = '{0, 32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 4'b0000, 8};
    vt[14] = '{0, 32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000, 8};
    vt[15] = '{0, 32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0001, 8};
    vt[16] = '{1, 32'h00003C00, 32'h00003C00, 1'b0, 32'h00004000, 4'b0000, 8};
    vt[17] = '{1, 32'h00007BFF, 32'h00007BFF, 1'b0, 32'h00007C00, 4'b0101, 8};

    i32.input_a = '0; i32.input_b = '0; i32.input_op = 1'b0;
    i32.input_a_stb = 1'b0; i32.input_b_stb = 1'b0; i32.output_z_ack = 1'b1;
    i16.input_a = '0; i16.input_b = '0; i16.input_op = 1'b0;
    i16.input_a_stb = 1'b0; i16.input_b_stb = 1'b0; i16.output_z_ack = 1'b1;

    // reset values, then acks rise on the first edge after release
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'b0, i32.input_a_ack | i32.input_b_ack}, 32'd0);
    chk("rst_stb", {31'b0, i32.output_z_stb}, 32'd0);
    chk("rst_z", i32.output_z, 32'd0);
    chk("rst_flags", {28'b0, i32.output_flags}, 32'd0);
    @(negedge clk) rstnn = 1'b1;
    @(posedge clk); #1;
    chk("ack_rise", {30'b0, i32.input_a_ack, i32.input_b_ack}, 32'd3);

    for (int i = 0; i < NV; i++) begin
      run_op(vt[i].h, vt[i].a, vt[i].b, vt[i].op, z, f, lat);
      chk($sformatf("v%0d_z", i), z, vt[i].z);
      chk($sformatf("v%0d_flags", i), {28'b0, f}, {28'b0, vt[i].f});
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].lat));
      @(posedge clk); #1;
      chk($sformatf("v%0d_stb_clear", i),
          {31'b0, (vt[i].h ? i16.output_z_stb : i32.output_z_stb)}, 32'd0);
      chk($sformatf("v%0d_ack_back", i),
          {31'b0, (vt[i].h ? i16.input_a_ack : i32.input_a_ack)}, 32'd1);
    end

    // back-pressure: result held stable for 10 cycles with ack low
    i32.output_z_ack = 1'b0;
    run_op(0, 32'h3F800000, 32'h40000000, 1'b0, z, f, lat);
    ok = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (!i32.output_z_stb || i32.output_z !== 32'h40400000 || i32.output_flags !== 4'b0000)
        ok = 1'b0;
    end
    chk("hold_stable", {31'b0, ok}, 32'd1);
    i32.output_z_ack = 1'b1;
    @(posedge clk); #1;
    chk("hold_release", {31'b0, i32.output_z_stb}, 32'd0);

    // a lone A strobe must not start an operation
    @(negedge clk);
    i32.input_a = 32'h3F800000; i32.input_a_stb = 1'b1;
    ok = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (!i32.input_a_ack) ok = 1'b0;
    end
    i32.input_a_stb = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (i32.output_z_stb) ok = 1'b0;
    end
    chk("single_stb", {31'b0, ok}, 32'd1);

    // reset asserted while the operation sits in ALIGN
    @(negedge clk);
    i32.input_a = 32'h3F800000; i32.input_b = 32'h40000000; i32.input_op = 1'b0;
    i32.input_a_stb = 1'b1; i32.input_b_stb = 1'b1;
    @(posedge clk); #1;
    i32.input_a_stb = 1'b0; i32.input_b_stb = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstnn = 1'b0;
    #1;
    chk("mid_rst_ack", {30'b0, i32.input_a_ack, i32.input_b_ack}, 32'd0);
    chk("mid_rst_stb", {31'b0, i32.output_z_stb}, 32'd0);
    chk("mid_rst_z", i32.output_z, 32'd0);
    chk("mid_rst_flags", {28'b0, i32.output_flags}, 32'd0);
    @(negedge clk) rstnn = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ack_rise", {31'b0, i32.input_a_ack}, 32'd1);
    ok = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (i32.output_z_stb) ok = 1'b0;
    end
    chk("mid_rst_no_result", {31'b0, ok}, 32'd1);

    run_op(0, 32'h40400000, 32'h3F800000, 1'b0, z, f, lat);
    chk("post_rst_z", z, 32'h40800000);
    chk("post_rst_lat", 32'(lat), 32'd8);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fp_addsub_param.md
# fp_addsub_param

Parametrised IEEE-754-style floating-point adder/subtractor with a per-operation add/sub mode and exception flags, for the floating-point coprocessor datapath. Handshake follows the platform's stb/ack operand convention. It is a multi-cycle FSM with fixed latency: barrel-shift alignment and leading-zero normalisation replace bit-serial loops. Supports any exponent/fraction width (fp16, fp32, bf16, …) with round-to-nearest-even.

## Interface
- EXP_W, 8, exponent field width (≥3).
- MAN_W, 23, stored fraction width (≥2); word width W = 1+EXP_W+MAN_W.
- clk  in  1  clock, rising edge.
- rstnn  in  1  reset, asynchronous, active-low.
- input_a  in  W  operand A.
- input_a_stb  in  1  A valid.
- input_a_ack  out  1  ready to accept A.
- input_b  in  W  operand B.
- input_b_stb  in  1  B valid.
- input_b_ack  out  1  ready to accept B.
- input_op  in  1  0 = A+B, 1 = A−B; sampled with operands.
- output_z  out  W  result.
- output_z_stb  out  1  result valid.
- output_z_ack  in  1  consumer accepts result.
- output_flags  out  4  [0] inexact, [1] underflow, [2] overflow, [3] invalid; valid with output_z_stb.

## Operation
- States: IDLE → UNPACK → SPECIAL → ALIGN → ADD → NORM → ROUND → PACK → OUT → IDLE.
- IDLE: both acks high. Operands and op are captured only when input_a_stb && input_b_stb in the same cycle. Acks drop the next cycle. A single strobe captures nothing.
- UNPACK: split sign/exp/fraction. For subtraction, invert B's sign. Restore the hidden bit for normals. Subnormal exponent = 1.
- SPECIAL: a NaN operand, or inf + opposite-sign inf, gives canonical NaN (sign 0, exp all ones, fraction MSB 1, rest 0). The opposite-sign inf case sets invalid; a signalling NaN (fraction MSB 0) also sets invalid. A single inf, or same-sign infs, gives inf of that sign. Special results jump straight to OUT.
- ALIGN: swap so |A| ≥ |B|. Right-shift the smaller significand by the exponent difference into a MAN_W+4-bit datapath (hidden, fraction, G, R, S). All bits shifted past S are ORed into S. Difference ≥ MAN_W+3 leaves only S.
- ADD: same effective sign adds; otherwise subtract smaller from larger. Result sign = sign of the larger magnitude.
- NORM: on carry-out, shift right 1 (sticky-preserving) and exp+1. Otherwise left-shift by leading-zero count, limited so the exponent does not fall below 1.
- ROUND: round-to-nearest-even on G/R/S. Inexact when G|R|S. A mantissa carry increments the exponent.
- PACK: exponent ≥ 2^EXP_W−1 gives inf of result sign with overflow and inexact set. Underflow is set when the result is tiny (subnormal or zero before rounding) and inexact.
- Exact-zero result is +0, except (−0)+(−0) and (−0)−(+0), which give −0.
- OUT: output_z/output_flags registered and held stable while output_z_stb is high. Transfer on output_z_stb && output_z_ack. output_z_stb is low the next cycle and the FSM returns to IDLE.

## Timing
- Reset values: input_a_ack=0, input_b_ack=0, output_z_stb=0, output_z=0, output_flags=0; state IDLE.
- Acks rise on the first clock edge after rstnn deasserts.
- Latency: capture at edge N; output_z_stb high after edge N+8 for all non-special inputs. Special cases give output_z_stb high after edge N+3.
- Throughput: one operation in flight. Minimum 10 cycles between captures with output_z_ack held high.
- rstnn low in any state: immediate return to reset values. The in-flight operation is discarded and no output is produced.
- output_z_ack outside OUT is ignored.

## Configuration
- FP_ADDSUB_SUBNORM_EN defined: gradual underflow. Subnormal inputs are used as-is and subnormal results are produced.
- Undefined: subnormal inputs are treated as zero of the same sign, with no flag. Results that are subnormal after rounding are flushed to zero of the result sign, with underflow and inexact set. The NORM shift limit still applies.

## Test plan
- Defaults, 0x3F800000 + 0x40000000, op=0 → 0x40400000, flags 0, stb after edge N+8.
- 0x3F800000 − 0x3F800000 (op=1) → 0x00000000, flags 0. Then 0x80000000 + 0x80000000 → 0x80000000.
- 0x7F800000 + 0xFF800000 → 0x7FC00000, flags 4'b1000. Then 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, flags 4'b0101.
- Tie case 0x3F800000 + 0x33800000 → 0x3F800000 (even), flags 4'b0001. 0x00000001 + 0x00000001 → 0x00000002 with the macro defined; 0x00000000, flags 0 without it.
- EXP_W=5, MAN_W=10: 0x3C00 + 0x3C00 → 0x4000, and 0x7BFF + 0x7BFF → 0x7C00, flags 4'b0101.
- Hold output_z_ack low 10 cycles → output_z/flags stable, stb high. Strobe only input_a_stb → no capture. Pull rstnn low in ALIGN → all outputs at reset values, no result emitted.
